// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce and signed 3-digit decimal entry.
// Committed entries are converted to an 8-bit two's-complement value on the enter key.
module keypad_entry #(
    parameter int SCAN_BITS      = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] num,
    output logic       num_valid,
    output logic       err,
    output logic       entry_neg,
    output logic [1:0] digit_cnt,
    output logic       key_strobe,
    output logic [3:0] key_code
);

    typedef enum logic {RELEASED, PRESSED} key_state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [SCAN_BITS-1:0] dwell;
    logic [1:0]           idx;
    logic [15:0]          frame;
    logic                 frame_done;
    logic                 dwell_last;

    assign dwell_last = &dwell;
    assign col        = ~(4'b0001 << idx);

    // Rows are sampled on the final dwell cycle so they have settled behind the column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell      <= '0;
            idx        <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            dwell      <= dwell + SCAN_BITS'(1);
            frame_done <= dwell_last && (idx == 2'd3);
            if (dwell_last) begin
                frame[{idx, 2'b00} +: 4] <= row;
                idx                      <= idx + 2'd1;
            end
        end
    end

    function automatic logic [3:0] key_map(input logic [3:0] pos);
        case (pos)
            4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;  default: key_map = 4'hD;
        endcase
    endfunction

    // Only a single low bit in the frame is a valid key; multiple lows are ghosting.
    logic [4:0] nlow;
    logic [3:0] pos;
    logic       present;
    logic [3:0] code;

    always_comb begin
        nlow = '0;
        pos  = '0;
        for (int i = 0; i < 16; i++) begin
            if (!frame[i]) begin
                nlow = nlow + 5'd1;
                pos  = 4'(i);
            end
        end
        present = (nlow == 5'd1);
        code    = key_map(pos);
    end

    key_state_t state, state_nx;
    logic [3:0] dcnt, dcnt_nx;
    logic [3:0] cand, cand_nx;
    logic       strobe_nx;
    logic [3:0] code_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            dcnt       <= '0;
            cand       <= '0;
            key_strobe <= 1'b0;
            key_code   <= '0;
        end else begin
            state      <= state_nx;
            dcnt       <= dcnt_nx;
            cand       <= cand_nx;
            key_strobe <= strobe_nx;
            key_code   <= code_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dcnt_nx   = dcnt;
        cand_nx   = cand;
        strobe_nx = 1'b0;
        code_nx   = key_code;
        if (frame_done) begin
            case (state)
                RELEASED: begin
                    if (!present)
                        dcnt_nx = '0;
                    else if (code == cand && dcnt != 4'd0)
                        dcnt_nx = dcnt + 4'd1;
                    else begin
                        dcnt_nx = 4'd1;
                        cand_nx = code;
                    end
                    if (dcnt_nx == DEB) begin
                        state_nx  = PRESSED;
                        dcnt_nx   = '0;
                        strobe_nx = 1'b1;
                        code_nx   = code;
                    end
                end
                default: begin
                    dcnt_nx = present ? 4'd0 : dcnt + 4'd1;
                    if (dcnt_nx == DEB) begin
                        state_nx = RELEASED;
                        dcnt_nx  = '0;
                    end
                end
            endcase
        end
    end

    logic [9:0] mag;
    logic       in_range;

    // Negative entries may reach 128 since -128 is representable.
    assign in_range = entry_neg ? (mag <= 10'd128) : (mag <= 10'd127);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            digit_cnt <= '0;
            entry_neg <= 1'b0;
            num       <= '0;
            num_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            num_valid <= 1'b0;
            err       <= 1'b0;
            if (key_strobe) begin
                if (key_code <= 4'd9) begin
                    if (digit_cnt != 2'd3) begin
                        mag       <= (mag << 3) + (mag << 1) + {6'd0, key_code};
                        digit_cnt <= digit_cnt + 2'd1;
                    end
                end else if (key_code == 4'hA) begin
                    entry_neg <= ~entry_neg;
                end else if (key_code == 4'hC || key_code == 4'hF) begin
                    if (key_code == 4'hF) begin
                        if (in_range) begin
                            num       <= entry_neg ? (~mag[7:0] + 8'd1) : mag[7:0];
                            num_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    mag       <= '0;
                    digit_cnt <= '0;
                    entry_neg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad matrix model drives rows from columns,
// expected strobes and commits are queued at stimulus time and popped as the DUT produces them.
module tb_keypad_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] num;
    logic       num_valid;
    logic       err;
    logic       entry_neg;
    logic [1:0] digit_cnt;
    logic       key_strobe;
    logic [3:0] key_code;

    keypad_entry #(.SCAN_BITS(2), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .num(num),
        .num_valid(num_valid), .err(err), .entry_neg(entry_neg),
        .digit_cnt(digit_cnt), .key_strobe(key_strobe), .key_code(key_code)
    );

    always #5 clk = ~clk;

    localparam int FRAME = 16;

    logic [15:0] keys;   // bit c*4+r set = key at column c, row r held down

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int strobes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [3:0] ks_q[$];
    logic [8:0] ev_q[$];   // {is_err, num}

    always @(negedge clk) begin
        if (rst_n) begin
            if (num_valid && err) chk("valid_err_both", 1, 0);
            if (key_strobe) begin
                strobes++;
                if (ks_q.size() == 0) chk("strobe_unexpected", {28'd0, key_code}, 32'hFFFF);
                else chk("key_code", {28'd0, key_code}, {28'd0, ks_q.pop_front()});
            end
            if (num_valid || err) begin
                if (ev_q.size() == 0) chk("commit_unexpected", {23'd0, err, num}, 32'hFFFF);
                else chk("commit", {23'd0, err, num}, {23'd0, ev_q.pop_front()});
            end
        end
    end

    // Entry model
    int         m_mag = 0;
    int         m_cnt = 0;
    bit         m_neg = 0;
    logic [7:0] m_num = 0;

    task automatic model_key(input logic [3:0] k);
        int lim;
        if (k <= 9) begin
            if (m_cnt < 3) begin m_mag = m_mag * 10 + int'(k); m_cnt++; end
        end else if (k == 4'hA) begin
            m_neg = !m_neg;
        end else if (k == 4'hC || k == 4'hF) begin
            if (k == 4'hF) begin
                lim = m_neg ? 128 : 127;
                if (m_mag <= lim) begin
                    m_num = m_neg ? 8'((256 - m_mag) % 256) : 8'(m_mag);
                    ev_q.push_back({1'b0, m_num});
                end else begin
                    ev_q.push_back({1'b1, m_num});
                end
            end
            m_mag = 0; m_cnt = 0; m_neg = 0;
        end
    endtask

    function automatic logic [15:0] mask_of(input logic [3:0] k);
        logic [3:0] tbl [16];
        tbl = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
        mask_of = '0;
        for (int i = 0; i < 16; i++) if (tbl[i] == k) mask_of[i] = 1'b1;
    endfunction

    task automatic press(input logic [3:0] k);
        ks_q.push_back(k);
        model_key(k);
        @(posedge clk); keys = mask_of(k);
        repeat (4*FRAME) @(posedge clk);
        keys = '0;
        repeat (4*FRAME) @(posedge clk);
    endtask

    int s0;

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, col}, 32'hE);
        chk("rst_outs", {20'd0, num, num_valid, err, entry_neg, digit_cnt, key_strobe},  32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("scan_col%0d", i), {28'd0, col}, {28'd0, ~(4'b0001 << (i % 4))});
            repeat (4) @(negedge clk);
        end

        // Digits and positive commit
        s0 = strobes;
        press(4'h1); press(4'h2); press(4'h5); press(4'hF);
        chk("strobes_125F", strobes - s0, 4);
        chk("num_7D", {24'd0, num}, 32'h7D);

        // Negative range edge, then one past it
        press(4'hA); press(4'h1); press(4'h2); press(4'h8);
        chk("neg_flag", {31'd0, entry_neg}, 32'd1);
        press(4'hF);
        chk("num_80", {24'd0, num}, 32'h80);
        press(4'hA); press(4'h1); press(4'h2); press(4'h9); press(4'hF);
        chk("num_held_neg", {24'd0, num}, 32'h80);
        chk("cnt_clr_neg", {30'd0, digit_cnt}, 32'd0);

        // Positive out of range, digit limit
        press(4'h1); press(4'h2); press(4'h8); press(4'hF);
        press(4'h4); press(4'h5); press(4'h6); press(4'h7);
        chk("cnt_limit", {30'd0, digit_cnt}, 32'd3);
        press(4'hF);
        chk("num_held_pos", {24'd0, num}, 32'h80);

        // Bounce: key toggles every frame, never two stable frames in a row
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? mask_of(4'h5) : 16'h0;
            repeat (FRAME) @(posedge clk);
        end
        keys = '0;
        repeat (4*FRAME) @(posedge clk);
        chk("bounce_nostrobe", strobes - s0, 0);

        // Long hold: one strobe only
        ks_q.push_back(4'h5); model_key(4'h5);
        keys = mask_of(4'h5);
        repeat (20*FRAME) @(posedge clk);
        keys = '0;
        repeat (4*FRAME) @(posedge clk);
        chk("hold_one_strobe", strobes - s0, 1);
        chk("hold_cnt", {30'd0, digit_cnt}, 32'(m_cnt));

        // Ghosting
        s0 = strobes;
        keys = mask_of(4'h1) | mask_of(4'h2);
        repeat (6*FRAME) @(posedge clk);
        keys = '0;
        repeat (4*FRAME) @(posedge clk);
        chk("ghost_nostrobe", strobes - s0, 0);

        press(4'h7); press(4'hC);
        chk("clr_cnt", {30'd0, digit_cnt}, 32'd0);
        press(4'hF);
        chk("num_zero", {24'd0, num}, 32'd0);

        // Reset mid-entry
        press(4'h3);
        chk("pre_rst_cnt", {30'd0, digit_cnt}, 32'd1);
        keys = mask_of(4'h4);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cnt", {30'd0, digit_cnt}, 32'd0);
        chk("midrst_num", {24'd0, num}, 32'd0);
        chk("midrst_col", {28'd0, col}, 32'hE);
        keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("ks_q_empty", ks_q.size(), 0);
        chk("ev_q_empty", ev_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the seven-segment output path. Scans a 4x4 matrix keypad by driving columns low in turn and sampling the rows.
- Debounces key presses and assembles a signed decimal entry of sign plus up to 3 digits.
- Converts the entry to an 8-bit two's-complement value. The result feeds the same datapath that the display block renders back as sign, hundreds, tens and ones.

Parameters:
- SCAN_BITS, 18: column dwell is 2^SCAN_BITS clk cycles.
- DEBOUNCE_SCANS, 4: consecutive identical scan frames needed to accept a press or a release. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row  input  4  keypad rows, active-low, externally pulled up
- col  output  4  keypad column drive, active-low, exactly one bit low
- num  output  8  last committed value, two's complement
- num_valid  output  1  one-cycle pulse when num updates
- err  output  1  one-cycle pulse on an out-of-range commit
- entry_neg  output  1  sign of the entry in progress
- digit_cnt  output  2  digits entered so far, 0..3
- key_strobe  output  1  one-cycle pulse per debounced press
- key_code  output  4  code of the last debounced press

Behaviour:
- Reset (async, rst_n=0):
  - col=4'b1110; num=0; num_valid=0; err=0; entry_neg=0; digit_cnt=0; key_strobe=0; key_code=0.
  - Internal: dwell counter, column index, frame buffer, debounce count and magnitude accumulator all cleared; key FSM in RELEASED.
- Scan:
  - Column index idx (2 bits) increments when the dwell counter reaches 2^SCAN_BITS-1, wrapping 3->0.
  - col = ~(1<<idx).
  - row is sampled on the last dwell cycle of each column, so rows settle for 2^SCAN_BITS-1 cycles.
  - A frame completes when column 3 is sampled. The frame result is computed in the cycle after the column-3 sample, using all 16 bits.
- Frame result:
  - Exactly one low bit among the 16 -> key present, with its code.
  - Zero low bits or more than one -> no key (ghosting is rejected).
- Key map (col0..col3, rows 0..3):
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
  - Codes equal the hex value.
- Debounce FSM:
  - RELEASED: track the candidate code. The counter increments on each frame with the same key present and resets to 1 on a different key; a no-key frame clears it. At DEBOUNCE_SCANS, go to PRESSED, latch key_code, and assert key_strobe for 1 cycle.
  - PRESSED: count consecutive no-key frames; any key-present frame resets the count. At DEBOUNCE_SCANS, go to RELEASED.
  - Exactly one strobe per press. A held key never repeats.
- Entry actions, in the cycle after key_strobe:
  - Digit 0-9:
    - If digit_cnt<3: mag <= mag*10 + d, computed as (mag<<3)+(mag<<1)+d; mag is 10 bits; digit_cnt++.
    - If digit_cnt=3: ignored.
  - A: toggle entry_neg.
  - C: clear mag, digit_cnt and entry_neg; num is unchanged.
  - F (enter), legal range is 0..127 when entry_neg=0, 0..128 when entry_neg=1:
    - In range: num <= entry_neg ? (~mag[7:0]+1) : mag[7:0]; num_valid pulses.
    - Out of range: err pulses; num is held.
    - In both cases the entry then clears as for C.
    - F with digit_cnt=0 commits 0. The result -0 is 0.
  - B, D, E: ignored.
- Timing: num_valid and err are registered and pulse exactly 1 cycle after the enter action cycle. They are never high together.
- Reset mid-operation: an immediate return to reset values. No partial commit; the next frame starts at column 0.

Test Plan (SCAN_BITS=2, DEBOUNCE_SCANS=2, one frame = 16 cycles):
- Reset: hold rst_n=0 with row=4'b1111 -> col=1110 and all outputs 0. Release -> col steps 1110, 1101, 1011, 0111 every 4 cycles and wraps.
- Digits and commit: press 1, 2, 5, then F, each held 4 frames and released 4 frames -> key_strobe 4 times, key_code 1,2,5,F; num=8'h7D; num_valid 1 pulse.
- Negative range: A, 1, 2, 8, F -> num=8'h80 with a num_valid pulse. Then A, 1, 2, 9, F -> err pulse, num stays 8'h80, digit_cnt=0.
- Positive out of range and digit limit: 1, 2, 8, F -> err pulse. Then 4, 5, 6, 7, F -> fourth digit ignored, err pulse, num unchanged.
- Bounce and hold: key 5 alternating present/absent each frame for 6 frames -> no strobe. Key 5 held 20 frames -> exactly 1 strobe.
- Ghosting, clear and reset: two keys held together -> no strobe. Then 7, C, F -> num=0 with num_valid. Assert rst_n=0 mid-entry -> digit_cnt=0 and num=0 immediately.
